// File: rtl/sprite_pkg.sv
// Shared sprite-drawer definitions: screen geometry, pixel widths and the draw-sequencer states.
// Reused by every per-sprite plot sink and by the top-level drawer mux.
package sprite_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } draw_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_coord_t;
endpackage

// File: rtl/plot_pipe_stage.sv
// Two-stage plot pipe: S1 holds the drawer coordinate until its ROM colour arrives,
// S2 clips/keys the pixel and registers the VGA write.
module plot_pipe_stage
  import sprite_pkg::*;
#(
  parameter int                    SCREEN_W   = sprite_pkg::SCREEN_W,
  parameter int                    SCREEN_H   = sprite_pkg::SCREEN_H,
  parameter bit                    TRANSP_EN  = 1'b1,
  parameter logic [COLOUR_W-1:0]   TRANSP_COL = 3'b000
) (
  input  logic                clock_all,
  input  logic                reset_all,
  input  logic                flush,
  input  logic                draw_enable,
  input  logic [X_W-1:0]      pix_x,
  input  logic [Y_W-1:0]      pix_y,
  input  logic [COLOUR_W-1:0] pix_colour,
  input  logic                erase,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                kept
);
  localparam logic [X_W:0] X_LIM = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] Y_LIM = SCREEN_H[Y_W:0];

  pix_coord_t s1;
  logic [1:0] vld_pipe;
  logic       keep;

  // Unsigned compare only: drawer-side wrap shows up as a small coordinate and is plotted.
  assign keep = vld_pipe[0] &&
                ({1'b0, s1.x} < X_LIM) && ({1'b0, s1.y} < Y_LIM) &&
                (erase || !TRANSP_EN || (pix_colour != TRANSP_COL));
  assign kept     = keep && !flush;
  assign vga_plot = vld_pipe[1];

  always_ff @(posedge clock_all or posedge reset_all) begin
    if (reset_all) begin
      s1         <= '0;
      vld_pipe   <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      s1.x        <= pix_x;
      s1.y        <= pix_y;
      vld_pipe[0] <= draw_enable && !flush;
      vld_pipe[1] <= kept;
      if (kept) begin
        vga_x      <= s1.x;
        vga_y      <= s1.y;
        vga_colour <= erase ? bg_colour : pix_colour;
      end
    end
  end
endmodule

// File: rtl/sprite_plot_sink.sv
// Consumer end of one sprite drawer: sequences the drawer, counts kept pixels and
// issues single-cycle plot writes (or background erase writes) to the VGA adapter.
module sprite_plot_sink
  import sprite_pkg::*;
#(
  parameter int                  SCREEN_W   = sprite_pkg::SCREEN_W,
  parameter int                  SCREEN_H   = sprite_pkg::SCREEN_H,
  parameter bit                  TRANSP_EN  = 1'b1,
  parameter logic [COLOUR_W-1:0] TRANSP_COL = 3'b000
) (
  input  logic                clock_all,
  input  logic                reset_all,
  input  logic                start,
  input  logic                abort,
  input  logic                erase,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic                draw_enable,
  input  logic [X_W-1:0]      pix_x,
  input  logic [Y_W-1:0]      pix_y,
  input  logic [COLOUR_W-1:0] pix_colour,
  input  logic                pix_done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                finished,
  output logic [11:0]         plot_count
);
  draw_state_t         state;
  logic                erase_q;
  logic [COLOUR_W-1:0] bg_q;
  logic                drain_cnt;
  logic                flush;
  logic                kept;

  assign flush = abort && ((state == DRAW) || (state == DRAIN));

  plot_pipe_stage #(
    .SCREEN_W  (SCREEN_W),
    .SCREEN_H  (SCREEN_H),
    .TRANSP_EN (TRANSP_EN),
    .TRANSP_COL(TRANSP_COL)
  ) u_pipe (
    .clock_all  (clock_all),
    .reset_all  (reset_all),
    .flush      (flush),
    .draw_enable(draw_enable),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .erase      (erase_q),
    .bg_colour  (bg_q),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .kept       (kept)
  );

  always_ff @(posedge clock_all or posedge reset_all) begin
    if (reset_all) begin
      state       <= IDLE;
      draw_enable <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      plot_count  <= '0;
      erase_q     <= 1'b0;
      bg_q        <= '0;
      drain_cnt   <= 1'b0;
    end else begin
      finished <= 1'b0;
      if (kept && (plot_count != 12'hFFF)) plot_count <= plot_count + 12'd1;
      case (state)
        IDLE: if (start && !abort) begin
          state       <= DRAW;
          draw_enable <= 1'b1;
          busy        <= 1'b1;
          erase_q     <= erase;
          bg_q        <= bg_colour;
          plot_count  <= '0;
        end
        DRAW: if (abort) begin
          state       <= IDLE;
          draw_enable <= 1'b0;
          busy        <= 1'b0;
        end else if (pix_done) begin
          // Drop enable on the edge that samples the last coordinate.
          state       <= DRAIN;
          draw_enable <= 1'b0;
          drain_cnt   <= 1'b0;
        end
        DRAIN: if (abort) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (drain_cnt) begin
          state    <= FIN;
          finished <= 1'b1;
        end else begin
          drain_cnt <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
